hms_set_cnt: RTL and testbench

//  Hour/minute/second timekeeping counter with button-driven time setting; upstream stage of
//  the 7-segment display chain. Counts on a 1 Hz enable pulse, and produces sec/min/hour values
//  for the double-figure split and FND decoders. It also produces a 6-bit DP mask for the

---
 rtl/hms_set_cnt_if.sv | 20 ++
 rtl/hms_set_cnt.sv | 124 ++++++++++++
 tb/tb_hms_set_cnt.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hms_set_cnt_if.sv
// Tick/button inputs and time/mode/DP outputs of the hms_set_cnt timekeeper.
interface hms_set_cnt_if;
    logic       i_tick;
    logic       i_sw_mode;
    logic       i_sw_up;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic [1:0] o_mode;
    logic [5:0] o_six_dp;

    modport master (
        output i_tick, i_sw_mode, i_sw_up,
        input  o_sec, o_min, o_hour, o_mode, o_six_dp
    );
    modport slave (
        input  i_tick, i_sw_mode, i_sw_up,
        output o_sec, o_min, o_hour, o_mode, o_six_dp
    );
endinterface

// File: rtl/hms_set_cnt.sv
// Hour/minute/second counter with debounced mode/up buttons for setting the time and a
// DP mask marking the field being set.
module hms_set_cnt #(
    parameter int unsigned DEB_CYC  = 500000,
    parameter int unsigned HOUR_MAX = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    hms_set_cnt_if.slave bus
);
    localparam int unsigned CW = $clog2(DEB_CYC);

    typedef enum logic [1:0] {
        StClock   = 2'd0,
        StSetSec  = 2'd1,
        StSetMin  = 2'd2,
        StSetHour = 2'd3
    } state_e;

    // Bit 0 = mode button, bit 1 = up button; all levels active-low.
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [CW-1:0] cnt_q [2];
    logic          mode_press, up_press;

    assign raw        = {bus.i_sw_up, bus.i_sw_mode};
    assign mode_press = press_q[0];
    assign up_press   = press_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            press_q    <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_prev_q & ~deb_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= CW'(DEB_CYC - 1)) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        return (v >= 5'(HOUR_MAX - 1)) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] dp_mask(input state_e s);
        logic [5:0] m;
        m = 6'b000000;
        unique case (s)
            StClock:   m = 6'b000000;
            StSetSec:  m = 6'b000011;
            StSetMin:  m = 6'b001100;
            StSetHour: m = 6'b110000;
        endcase
        return m;
    endfunction

    state_e     state_q, state_nx;
    logic [5:0] sec_q, min_q, dp_q;
    logic [4:0] hour_q;

    assign state_nx = state_e'(state_q + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClock;
            dp_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
        end else begin
            if (mode_press) begin
                state_q <= state_nx;
                dp_q    <= dp_mask(state_nx);
            end
            // Actions follow the current state, so a tick is still honoured on the cycle
            // CLOCK is left and ignored on the cycle it is re-entered.
            unique case (state_q)
                StClock: begin
                    if (bus.i_tick) begin
                        if (sec_q >= 6'd59) begin
                            sec_q <= '0;
                            if (min_q >= 6'd59) begin
                                min_q  <= '0;
                                hour_q <= inc_hour(hour_q);
                            end else begin
                                min_q <= min_q + 6'd1;
                            end
                        end else begin
                            sec_q <= sec_q + 6'd1;
                        end
                    end
                end
                StSetSec:  if (up_press && !mode_press) sec_q  <= inc60(sec_q);
                StSetMin:  if (up_press && !mode_press) min_q  <= inc60(min_q);
                StSetHour: if (up_press && !mode_press) hour_q <= inc_hour(hour_q);
            endcase
        end
    end

    assign bus.o_sec    = sec_q;
    assign bus.o_min    = min_q;
    assign bus.o_hour   = hour_q;
    assign bus.o_mode   = state_q;
    assign bus.o_six_dp = dp_q;
endmodule

// File: tb/tb_hms_set_cnt.sv
// Directed bench for hms_set_cnt: a vector table for counting/setting plus hand-written
// debounce, simultaneous-event and reset sequences.
module tb_hms_set_cnt;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hms_set_cnt_if bus ();

    hms_set_cnt #(
        .DEB_CYC (4),
        .HOUR_MAX(24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {OpTick, OpMode, OpUp} op_e;

    typedef struct {
        op_e        op;
        int         n;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [1:0] mode;
        logic [5:0] dp;
    } vec_t;

    vec_t vec [21];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [5:0] sec, input logic [5:0] min,
                             input logic [4:0] hour, input logic [1:0] mode,
                             input logic [5:0] dp);
        check({name, ".sec"}, 8'(bus.o_sec), 8'(sec));
        check({name, ".min"}, 8'(bus.o_min), 8'(min));
        check({name, ".hour"}, 8'(bus.o_hour), 8'(hour));
        check({name, ".mode"}, 8'(bus.o_mode), 8'(mode));
        check({name, ".dp"}, 8'(bus.o_six_dp), 8'(dp));
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_tick = 1'b1;
        end
        @(negedge clk);
        bus.i_tick = 1'b0;
    endtask

    // Hold long enough for one pulse, then release long enough for the release to settle.
    task automatic press(input logic do_mode, input logic do_up);
        @(negedge clk);
        if (do_mode) bus.i_sw_mode = 1'b0;
        if (do_up) bus.i_sw_up = 1'b0;
        repeat (8) @(negedge clk);
        bus.i_sw_mode = 1'b1;
        bus.i_sw_up   = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.i_tick    = 1'b0;
        bus.i_sw_mode = 1'b1;
        bus.i_sw_up   = 1'b1;
        rst_n = 1'b0;

        vec[0]  = '{OpTick, 59, 6'd59, 6'd0,  5'd0,  2'd0, 6'b000000};
        vec[1]  = '{OpTick, 1,  6'd0,  6'd1,  5'd0,  2'd0, 6'b000000};
        vec[2]  = '{OpMode, 1,  6'd0,  6'd1,  5'd0,  2'd1, 6'b000011};
        vec[3]  = '{OpUp,   59, 6'd59, 6'd1,  5'd0,  2'd1, 6'b000011};
        vec[4]  = '{OpMode, 1,  6'd59, 6'd1,  5'd0,  2'd2, 6'b001100};
        vec[5]  = '{OpUp,   58, 6'd59, 6'd59, 5'd0,  2'd2, 6'b001100};
        vec[6]  = '{OpMode, 1,  6'd59, 6'd59, 5'd0,  2'd3, 6'b110000};
        vec[7]  = '{OpUp,   23, 6'd59, 6'd59, 5'd23, 2'd3, 6'b110000};
        vec[8]  = '{OpMode, 1,  6'd59, 6'd59, 5'd23, 2'd0, 6'b000000};
        vec[9]  = '{OpTick, 1,  6'd0,  6'd0,  5'd0,  2'd0, 6'b000000};
        vec[10] = '{OpTick, 3,  6'd3,  6'd0,  5'd0,  2'd0, 6'b000000};
        vec[11] = '{OpMode, 1,  6'd3,  6'd0,  5'd0,  2'd1, 6'b000011};
        vec[12] = '{OpTick, 5,  6'd3,  6'd0,  5'd0,  2'd1, 6'b000011};
        vec[13] = '{OpMode, 1,  6'd3,  6'd0,  5'd0,  2'd2, 6'b001100};
        vec[14] = '{OpUp,   59, 6'd3,  6'd59, 5'd0,  2'd2, 6'b001100};
        vec[15] = '{OpUp,   1,  6'd3,  6'd0,  5'd0,  2'd2, 6'b001100};
        vec[16] = '{OpMode, 1,  6'd3,  6'd0,  5'd0,  2'd3, 6'b110000};
        vec[17] = '{OpUp,   25, 6'd3,  6'd0,  5'd1,  2'd3, 6'b110000};
        vec[18] = '{OpMode, 1,  6'd3,  6'd0,  5'd1,  2'd0, 6'b000000};
        vec[19] = '{OpUp,   2,  6'd3,  6'd0,  5'd1,  2'd0, 6'b000000};
        vec[20] = '{OpTick, 57, 6'd0,  6'd1,  5'd1,  2'd0, 6'b000000};

        repeat (3) @(negedge clk);
        check_all("reset", 6'd0, 6'd0, 5'd0, 2'd0, 6'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            unique case (vec[i].op)
                OpTick: ticks(vec[i].n);
                OpMode: repeat (vec[i].n) press(1'b1, 1'b0);
                OpUp:   repeat (vec[i].n) press(1'b0, 1'b1);
            endcase
            check_all($sformatf("row%0d", i), vec[i].sec, vec[i].min, vec[i].hour,
                      vec[i].mode, vec[i].dp);
        end

        // Glitches of 2 and 3 cycles must not register; time is 01:01:00 in CLOCK.
        for (int g = 2; g <= 3; g++) begin
            @(negedge clk);
            bus.i_sw_mode = 1'b0;
            repeat (g) @(negedge clk);
            bus.i_sw_mode = 1'b1;
            repeat (12) @(negedge clk);
            check($sformatf("glitch%0d.mode", g), 8'(bus.o_mode), 8'd0);
        end

        // 10-cycle hold: mode changes exactly at cycle 8; a tick on that edge still counts.
        @(negedge clk);
        bus.i_sw_mode = 1'b0;
        repeat (7) @(negedge clk);
        check("hold.c7.mode", 8'(bus.o_mode), 8'd0);
        bus.i_tick = 1'b1;
        @(negedge clk);
        bus.i_tick = 1'b0;
        check("hold.c8.mode", 8'(bus.o_mode), 8'd1);
        check("hold.c8.dp", 8'(bus.o_six_dp), 8'b000011);
        check("hold.c8.sec", 8'(bus.o_sec), 8'd1);
        repeat (2) @(negedge clk);
        bus.i_sw_mode = 1'b1;
        repeat (12) @(negedge clk);
        check_all("hold.once", 6'd1, 6'd1, 5'd1, 2'd1, 6'b000011);

        // Mode and up pulse together in SET_SEC: mode wins, sec untouched.
        press(1'b1, 1'b1);
        check_all("both", 6'd1, 6'd1, 5'd1, 2'd2, 6'b001100);

        // SET_HOUR -> CLOCK with a tick on the transition edge: tick is dropped.
        press(1'b1, 1'b0);
        check("sethour.mode", 8'(bus.o_mode), 8'd3);
        @(negedge clk);
        bus.i_sw_mode = 1'b0;
        repeat (7) @(negedge clk);
        bus.i_tick = 1'b1;
        @(negedge clk);
        bus.i_tick = 1'b0;
        check_all("exit.tick", 6'd1, 6'd1, 5'd1, 2'd0, 6'd0);
        bus.i_sw_mode = 1'b1;
        repeat (12) @(negedge clk);

        // Asynchronous reset while counting and mid-debounce.
        ticks(4);
        check("prerst.sec", 8'(bus.o_sec), 8'd5);
        @(negedge clk);
        bus.i_sw_mode = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 6'd0, 6'd0, 5'd0, 2'd0, 6'd0);
        bus.i_sw_mode = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("post_rst", 6'd0, 6'd0, 5'd0, 2'd0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
